// File: rtl/ps2_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_rx : PS/2 device-to-host receiver (sync, clock deglitch, 11-bit       |
// |          frame check). Optional make/break tracker under PS2_EXTKEY_EN.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ps2_rx #(
  parameter int CLK_HZ     = 32000000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error,
  output logic       busy,
  output logic [7:0] key_code,
  output logic       key_release,
  output logic       key_extended,
  output logic       key_valid
);

  localparam int c_TIMEOUT_CYC = (CLK_HZ / 1000000) * TIMEOUT_US;
  localparam int c_TMO_W       = $clog2(c_TIMEOUT_CYC + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LIMIT = c_TMO_W'(c_TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic                  r_clk_meta, r_clk_sync;
  logic                  r_data_meta, r_data_sync;
  logic [FILTER_LEN-1:0] r_filt_sh;
  logic                  r_filt_clk;
  state_t                r_state, w_state_nxt;
  logic [2:0]            r_bitcnt, w_bitcnt_nxt;
  logic [7:0]            r_shift, w_shift_nxt;
  logic                  r_parity, w_parity_nxt;
  logic [7:0]            r_rx_data, w_data_nxt;
  logic                  r_rx_valid, w_valid_nxt;
  logic                  r_rx_error, w_error_nxt;
  logic [c_TMO_W-1:0]    r_tmo_cnt;
  logic                  w_fall;
  logic                  w_tmo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
      r_filt_sh   <= '1;
      r_filt_clk  <= 1'b1;
    end else begin
      r_clk_meta  <= ps2_clk;
      r_clk_sync  <= r_clk_meta;
      r_data_meta <= ps2_data;
      r_data_sync <= r_data_meta;
      r_filt_sh   <= {r_filt_sh[FILTER_LEN-2:0], r_clk_sync};
      if (~|r_filt_sh)
        r_filt_clk <= 1'b0;
      else if (&r_filt_sh)
        r_filt_clk <= 1'b1;
    end
  end

  // Falling edge of the filtered clock, seen one cycle before r_filt_clk drops.
  assign w_fall = r_filt_clk & ~|r_filt_sh;
  assign w_tmo  = (r_state != S_IDLE) && (r_tmo_cnt == c_TMO_LIMIT);

  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    w_data_nxt   = r_rx_data;
    w_valid_nxt  = 1'b0;
    w_error_nxt  = 1'b0;
    if (w_fall) begin
      case (r_state)
        S_IDLE: begin
          if (!r_data_sync) begin
            w_state_nxt  = S_DATA;
            w_bitcnt_nxt = 3'd0;
          end
        end
        S_DATA: begin
          w_shift_nxt  = {r_data_sync, r_shift[7:1]};
          w_bitcnt_nxt = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7)
            w_state_nxt = S_PARITY;
        end
        S_PARITY: begin
          w_parity_nxt = r_data_sync;
          w_state_nxt  = S_STOP;
        end
        S_STOP: begin
          w_state_nxt = S_IDLE;
          if (r_data_sync && (^{r_shift, r_parity})) begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = r_shift;
          end else begin
            w_error_nxt = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (w_tmo) begin
      w_state_nxt = S_IDLE;
      w_error_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_bitcnt   <= 3'd0;
      r_shift    <= 8'h00;
      r_parity   <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_rx_error <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_shift    <= w_shift_nxt;
      r_parity   <= w_parity_nxt;
      r_rx_data  <= w_data_nxt;
      r_rx_valid <= w_valid_nxt;
      r_rx_error <= w_error_nxt;
    end
  end

  // Inter-edge watchdog; saturates so a stuck line can never wrap it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_tmo_cnt <= '0;
    else if (w_fall || (r_state == S_IDLE))
      r_tmo_cnt <= '0;
    else if (r_tmo_cnt != c_TMO_LIMIT)
      r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
  end

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rx_error = r_rx_error;
  assign busy     = (r_state != S_IDLE);

`ifdef PS2_EXTKEY_EN
  logic       r_ext, r_rel;
  logic [7:0] r_key_code;
  logic       r_key_release, r_key_extended, r_key_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ext          <= 1'b0;
      r_rel          <= 1'b0;
      r_key_code     <= 8'h00;
      r_key_release  <= 1'b0;
      r_key_extended <= 1'b0;
      r_key_valid    <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (r_rx_error) begin
        r_ext <= 1'b0;
        r_rel <= 1'b0;
      end else if (r_rx_valid) begin
        if (r_rx_data == 8'hE0)
          r_ext <= 1'b1;
        else if (r_rx_data == 8'hF0)
          r_rel <= 1'b1;
        else begin
          r_key_code     <= r_rx_data;
          r_key_extended <= r_ext;
          r_key_release  <= r_rel;
          r_key_valid    <= 1'b1;
          r_ext          <= 1'b0;
          r_rel          <= 1'b0;
        end
      end
    end
  end

  assign key_code     = r_key_code;
  assign key_release  = r_key_release;
  assign key_extended = r_key_extended;
  assign key_valid    = r_key_valid;
`else
  assign key_code     = 8'h00;
  assign key_release  = 1'b0;
  assign key_extended = 1'b0;
  assign key_valid    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
PS/2 device-to-host receiver that sits between the keyboard pins and the BBC core's keyboard matrix logic. It synchronises and deglitches the raw PS/2 clock/data lines and deserialises 11-bit frames. It checks start, odd-parity and stop bits and delivers each byte as a one-cycle strobe. It runs on the 32 MHz system clock.

Parameters:
CLK_HZ, 32000000, system clock frequency in Hz.
FILTER_LEN, 8, number of consecutive identical samples required before the filtered ps2_clk level changes (2..16).
TIMEOUT_US, 2000, maximum gap in microseconds between falling edges inside a frame before the frame is abandoned.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
ps2_clk  input  1  raw PS/2 clock pin, asynchronous to clk.
ps2_data  input  1  raw PS/2 data pin, asynchronous to clk.
rx_data  output  8  last correctly received byte; holds its value until the next good frame.
rx_valid  output  1  one-cycle strobe; rx_data is new.
rx_error  output  1  one-cycle strobe on a framing error, parity error or timeout.
busy  output  1  high while a frame is in progress (state != IDLE).
key_code  output  8  decoded scan code (PS2_EXTKEY_EN only).
key_release  output  1  key_code is a break code (PS2_EXTKEY_EN only).
key_extended  output  1  key_code was E0-prefixed (PS2_EXTKEY_EN only).
key_valid  output  1  one-cycle strobe; the key_* outputs are new (PS2_EXTKEY_EN only).

Behaviour:
- Reset: every output is 0, the state is IDLE, and the filtered clock is 1.
- Reset is asynchronous and active-high. Asserting it mid-frame discards the partial frame and produces no strobe.
- Synchronisation: each input passes through a 2-flop synchroniser.
- Clock filter: shift register FILTER_LEN deep. The filtered clock goes to 0 only when all samples are 0, and to 1 only when all samples are 1; otherwise it holds.
- Sample event: a 1-to-0 transition of the filtered clock. Synchronised data is sampled in the same cycle.
- Data path: the data line is synchronised only, with no filter. It is stable across the falling edge by protocol.
- States:
  - IDLE: on a sample event with data=0, go to DATA with bitcnt=0. A sample with data=1 is ignored and raises no error.
  - DATA: shift data in LSB-first on each sample. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: on the sample event, go to IDLE.
    - If stop=1 and the XOR of the 8 data bits and the parity bit is 1: rx_data is updated and rx_valid pulses in the next cycle.
    - Otherwise: rx_error pulses in the next cycle and rx_data is unchanged.
- Timeout: counter limit TIMEOUT_CYC = (CLK_HZ/1000000)*TIMEOUT_US. The counter clears on every sample event and in IDLE.
  - If it reaches TIMEOUT_CYC in any non-IDLE state: go to IDLE and pulse rx_error once.
  - The counter saturates and never wraps.
- rx_valid and rx_error are never high in the same cycle.
- Latency: rx_valid is high exactly 1 clk after the stop-bit sample event. The end-to-end latency from the pin is 2 + FILTER_LEN + 1 cycles after the stop-bit falling edge.

Optional Feature:
Macro PS2_EXTKEY_EN.
- Defined:
  - A prefix tracker consumes each rx_valid byte.
  - 0xE0 sets the ext flag. 0xF0 sets the rel flag.
  - Any other byte: key_code=byte, key_extended=ext, key_release=rel, key_valid pulses 1 cycle after rx_valid, then both flags clear.
  - rx_error clears both flags.
  - 0xE1 (Pause) is passed through as an ordinary code.
- Not defined:
  - The key_* ports exist but are tied to 0.
  - There is no tracker logic.

Test Plan:
- Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at a 12.5 kHz PS/2 clock -> one rx_valid pulse, rx_data=0x1C, rx_error stays 0, busy drops with the strobe.
- Same frame with parity=1 -> rx_error pulses once, no rx_valid, rx_data keeps its previous value.
- 3-cycle low glitch on ps2_clk while IDLE, with data=0 -> no state change, busy stays 0. Then a valid 0x29 frame -> rx_data=0x29.
- Frame stopped after 4 data bits, lines idle high -> busy=1 until TIMEOUT_CYC=64000 cycles, then rx_error pulses once and busy=0. Next frame 0x5A is received correctly.
- reset pulse after the 5th bit of a frame -> all outputs 0 immediately, no strobes. Next full frame 0x66 -> rx_valid with rx_data=0x66.
- (PS2_EXTKEY_EN) Bytes E0, F0, 75 -> a single key_valid with key_code=0x75, key_release=1, key_extended=1. A following 0x1C -> key_release=0, key_extended=0.
